// File: rtl/button_event_decoder.sv
// button_event_decoder: turns debounced button levels into one-cycle press/click/long/repeat/release pulses
//   clk         system clock, rising edge
//   rst_n       synchronous reset, active-low
//   results_i   debounced button levels, 1 = pressed
//   press_o     pulse on a 0->1 edge
//   click_o     pulse on release before the long-press threshold
//   long_o      pulse when a hold reaches LONG_CYCLES
//   repeat_o    pulse every REPEAT_CYCLES while held past long (0 disables)
//   release_o   pulse on any tracked release
//   busy_o      some lane is not idle
module button_event_decoder #(
    parameter int NUM_BUTTONS   = 5,
    parameter int LONG_CYCLES   = 5000000,
    parameter int REPEAT_CYCLES = 1000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_BUTTONS-1:0] results_i,
    output logic [NUM_BUTTONS-1:0] press_o,
    output logic [NUM_BUTTONS-1:0] click_o,
    output logic [NUM_BUTTONS-1:0] long_o,
    output logic [NUM_BUTTONS-1:0] repeat_o,
    output logic [NUM_BUTTONS-1:0] release_o,
    output logic                   busy_o
);
    localparam int MAXC = LONG_CYCLES > REPEAT_CYCLES ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CYCLES == 0 ? 0 : REPEAT_CYCLES - 1);
    typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_e;
    state_e state_q [NUM_BUTTONS];
    state_e state_d [NUM_BUTTONS];
    logic [CW-1:0] cnt_q [NUM_BUTTONS];
    logic [CW-1:0] cnt_d [NUM_BUTTONS];
    // prev_q resets to 1 so a button held through reset never looks like a new press
    logic [NUM_BUTTONS-1:0] prev_q;
    logic [NUM_BUTTONS-1:0] press_d, click_d, long_d, repeat_d, release_d;
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        press_d = '0;
        click_d = '0;
        long_d = '0;
        repeat_d = '0;
        release_d = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            case (state_q[i])
                IDLE: begin
                    if (results_i[i] && !prev_q[i]) begin
                        state_d[i] = PRESSED;
                        cnt_d[i] = '0;
                        press_d[i] = 1'b1;
                    end
                end
                PRESSED: begin
                    // a release in the threshold cycle wins over long
                    if (!results_i[i]) begin
                        state_d[i] = IDLE;
                        click_d[i] = 1'b1;
                        release_d[i] = 1'b1;
                    end else if (cnt_q[i] == LONG_LAST) begin
                        state_d[i] = HELD;
                        cnt_d[i] = '0;
                        long_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
                HELD: begin
                    // with repeat disabled the counter simply holds
                    if (!results_i[i]) begin
                        state_d[i] = IDLE;
                        release_d[i] = 1'b1;
                    end else if (REPEAT_CYCLES != 0 && cnt_q[i] == REP_LAST) begin
                        cnt_d[i] = '0;
                        repeat_d[i] = 1'b1;
                    end else if (REPEAT_CYCLES != 0) begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end
    always_comb begin
        busy_o = 1'b0;
        for (int i = 0; i < NUM_BUTTONS; i++) busy_o = busy_o | (state_q[i] != IDLE);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i] <= '0;
            end
            prev_q <= '1;
            press_o <= '0;
            click_o <= '0;
            long_o <= '0;
            repeat_o <= '0;
            release_o <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            prev_q <= results_i;
            press_o <= press_d;
            click_o <= click_d;
            long_o <= long_d;
            repeat_o <= repeat_d;
            release_o <= release_d;
        end
    end
endmodule

// File: tb/tb_button_event_decoder.sv
// tb_button_event_decoder: directed table and hold sequences for button_event_decoder
module tb_button_event_decoder;
    localparam int L = 8;
    localparam logic [4:0] Z = 5'b00000;
    typedef logic [25:0] ov_t;
    typedef struct {
        int n;
        logic rst;
        logic [4:0] res;
        ov_t exp;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [4:0] results = '0;
    logic [4:0] press0, click0, long0, rep0, rel0, press1, click1, long1, rep1, rel1;
    logic busy0, busy1;
    int errors = 0;
    int checks = 0;
    vec_t tbl [19];
    always #5 clk = ~clk;
    button_event_decoder #(.NUM_BUTTONS(5), .LONG_CYCLES(8), .REPEAT_CYCLES(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .results_i(results), .press_o(press0), .click_o(click0),
        .long_o(long0), .repeat_o(rep0), .release_o(rel0), .busy_o(busy0));
    button_event_decoder #(.NUM_BUTTONS(5), .LONG_CYCLES(8), .REPEAT_CYCLES(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .results_i(results), .press_o(press1), .click_o(click1),
        .long_o(long1), .repeat_o(rep1), .release_o(rel1), .busy_o(busy1));
    wire ov_t o0 = {press0, click0, long0, rep0, rel0, busy0};
    wire ov_t o1 = {press1, click1, long1, rep1, rel1, busy1};
    function automatic ov_t mk(input logic [4:0] p, c, l, r, rl, input logic b);
        return {p, c, l, r, rl, b};
    endfunction
    // expected outputs k cycles after the press sample of a hold lasting h cycles
    function automatic ov_t exp_vec(input int k, input int h, input int lane, input int rc);
        logic [4:0] m;
        m = 5'(1) << lane;
        return mk(k == 0 ? m : Z,
                  (k == h && h <= L) ? m : Z,
                  (k == L && k < h) ? m : Z,
                  (rc != 0 && k > L && k < h && (k - L) % (rc == 0 ? 1 : rc) == 0) ? m : Z,
                  k == h ? m : Z,
                  k < h);
    endfunction
    task automatic apply(input logic r, input logic [4:0] res);
        rst_n = r;
        results = res;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string nm, input ov_t act, input ov_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (press,click,long,repeat,release,busy)", nm, act, exp);
        end
    endtask
    task automatic hold(input int lane, input int h);
        for (int k = 0; k <= h; k++) begin
            apply(1'b1, k < h ? 5'(1) << lane : Z);
            chk($sformatf("hold r4 lane%0d h%0d k%0d", lane, h, k), o0, exp_vec(k, h, lane, 4));
            chk($sformatf("hold r0 lane%0d h%0d k%0d", lane, h, k), o1, exp_vec(k, h, lane, 0));
        end
    endtask
    initial begin
        tbl = '{
            '{1, 1'b0, 5'b00000, mk(Z, Z, Z, Z, Z, 1'b0)},
            '{1, 1'b1, 5'b00000, mk(Z, Z, Z, Z, Z, 1'b0)},
            '{1, 1'b1, 5'b00001, mk(5'b00001, Z, Z, Z, Z, 1'b1)},
            '{2, 1'b1, 5'b00001, mk(Z, Z, Z, Z, Z, 1'b1)},
            '{1, 1'b1, 5'b00000, mk(Z, 5'b00001, Z, Z, 5'b00001, 1'b0)},
            '{1, 1'b1, 5'b00000, mk(Z, Z, Z, Z, Z, 1'b0)},
            '{1, 1'b1, 5'b10100, mk(5'b10100, Z, Z, Z, Z, 1'b1)},
            '{1, 1'b1, 5'b10100, mk(Z, Z, Z, Z, Z, 1'b1)},
            '{1, 1'b1, 5'b10000, mk(Z, 5'b00100, Z, Z, 5'b00100, 1'b1)},
            '{1, 1'b1, 5'b10000, mk(Z, Z, Z, Z, Z, 1'b1)},
            '{1, 1'b1, 5'b00000, mk(Z, 5'b10000, Z, Z, 5'b10000, 1'b0)},
            '{1, 1'b1, 5'b00010, mk(5'b00010, Z, Z, Z, Z, 1'b1)},
            '{1, 1'b1, 5'b00000, mk(Z, 5'b00010, Z, Z, 5'b00010, 1'b0)},
            '{2, 1'b0, 5'b01000, mk(Z, Z, Z, Z, Z, 1'b0)},
            '{10, 1'b1, 5'b01000, mk(Z, Z, Z, Z, Z, 1'b0)},
            '{2, 1'b1, 5'b00000, mk(Z, Z, Z, Z, Z, 1'b0)},
            '{1, 1'b1, 5'b01000, mk(5'b01000, Z, Z, Z, Z, 1'b1)},
            '{2, 1'b1, 5'b01000, mk(Z, Z, Z, Z, Z, 1'b1)},
            '{1, 1'b1, 5'b00000, mk(Z, 5'b01000, Z, Z, 5'b01000, 1'b0)}
        };
        for (int i = 0; i < 19; i++) begin
            for (int j = 0; j < tbl[i].n; j++) begin
                apply(tbl[i].rst, tbl[i].res);
                chk($sformatf("table r4 row%0d cyc%0d", i, j), o0, tbl[i].exp);
                chk($sformatf("table r0 row%0d cyc%0d", i, j), o1, tbl[i].exp);
            end
        end
        hold(4, 1);
        hold(0, 7);
        hold(0, 8);
        hold(0, 9);
        hold(1, 20);
        hold(1, 30);
        for (int k = 0; k < 10; k++) begin
            apply(1'b1, 5'b00001);
            chk($sformatf("midreset r4 k%0d", k), o0, exp_vec(k, 100, 0, 4));
            chk($sformatf("midreset r0 k%0d", k), o1, exp_vec(k, 100, 0, 0));
        end
        apply(1'b0, 5'b00001);
        chk("midreset pulse r4", o0, '0);
        chk("midreset pulse r0", o1, '0);
        for (int k = 0; k < 5; k++) begin
            apply(1'b1, k < 3 ? 5'b00001 : Z);
            chk($sformatf("after reset r4 k%0d", k), o0, '0);
            chk($sformatf("after reset r0 k%0d", k), o1, '0);
        end
        hold(0, 2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
